// File: rtl/pulse_sync_rx_if.sv
// Handshake bundle between a req/ack source-side consumer and pulse_sync_rx.
// master drives req/ready; slave is the synchronizer endpoint.
interface pulse_sync_rx_if #(
    parameter int EVT_CNT_W = 8
);
    logic                 req_in;
    logic                 ack_out;
    logic                 sig_sync;
    logic                 sig_ready;
    logic                 busy;
    logic [EVT_CNT_W-1:0] evt_cnt;
    logic                 timeout_err;

    modport master (
        output req_in,
        output sig_ready,
        input  ack_out,
        input  sig_sync,
        input  busy,
        input  evt_cnt,
        input  timeout_err
    );

    modport slave (
        input  req_in,
        input  sig_ready,
        output ack_out,
        output sig_sync,
        output busy,
        output evt_cnt,
        output timeout_err
    );
endinterface

// File: rtl/pulse_sync_rx.sv
// Receive end of a 4-phase req/ack pulse synchronizer with valid/ready delivery.
// Optional ack timeout monitor: define PULSE_SYNC_RX_TIMEOUT_EN.
module pulse_sync_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int EVT_CNT_W   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_sync_rx_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic [EVT_CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_e                 state_q, state_d;
    logic [EVT_CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic                   xfer;

    // Only this chain touches the asynchronous request level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign xfer  = (state_q == PEND) && bus.sig_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_s) state_d = PEND;
            PEND:    if (xfer) state_d = ACK;
            ACK:     if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (xfer && evt_cnt_q != CNT_MAX) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.sig_sync = (state_q == PEND);
        bus.ack_out  = (state_q == ACK);
        bus.busy     = (state_q != IDLE);
        bus.evt_cnt  = evt_cnt_q;
    end

`ifdef PULSE_SYNC_RX_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Count stays parked at the limit; the flag is sticky until reset.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        if (state_q != ACK && state_d == ACK) begin
            tmo_cnt_d = '0;
        end else if (state_q == ACK && req_s && tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (state_q == ACK && tmo_cnt_d == TMO_MAX) begin
            tmo_err_d = 1'b1;
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    logic unused_tmo;
    assign unused_tmo      = (TIMEOUT_CYC == 0);
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_sync_rx.sv
// Scoreboard bench for pulse_sync_rx: main instance plus a 2-bit counter
// instance fed identical stimulus to observe saturation.
module tb_pulse_sync_rx;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_q[$];

    pulse_sync_rx_if #(.EVT_CNT_W(8)) m_if ();
    pulse_sync_rx_if #(.EVT_CNT_W(2)) s_if ();

    pulse_sync_rx #(
        .SYNC_STAGES(2),
        .EVT_CNT_W  (8),
        .TIMEOUT_CYC(8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(m_if)
    );

    pulse_sync_rx #(
        .SYNC_STAGES(2),
        .EVT_CNT_W  (2),
        .TIMEOUT_CYC(8)
    ) u_sat (
        .clk(clk),
        .rst(rst),
        .bus(s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PULSE_SYNC_RX_TIMEOUT_EN
    localparam int EXP_TMO = 1;
`else
    localparam int EXP_TMO = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v);
        m_if.req_in = v;
        s_if.req_in = v;
    endtask

    task automatic set_rdy(input logic v);
        m_if.sig_ready = v;
        s_if.sig_ready = v;
    endtask

    task automatic handshake(input int k);
        set_rdy(1'b1);
        set_req(1'b1);
        exp_q.push_back(k);
        tick(4);
        check("hs_ack", int'(m_if.ack_out), 1);
        set_req(1'b0);
        tick(3);
        check("hs_idle", int'(m_if.busy), 0);
    endtask

    // Monitor: every transfer consumes one expectation.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && m_if.sig_sync && m_if.sig_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got transfer expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check("evt_cnt", int'(m_if.evt_cnt), e);
                    check("sat_cnt", int'(s_if.evt_cnt), (e > 3) ? 3 : e);
                    check("ack_after_xfer", int'(m_if.ack_out), 1);
                end
            end
        end
    end

    initial begin
        int held;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_req(1'b0);
        set_rdy(1'b0);
        tick(2);
        check("rst_sig_sync", int'(m_if.sig_sync), 0);
        check("rst_ack", int'(m_if.ack_out), 0);
        check("rst_busy", int'(m_if.busy), 0);
        check("rst_evt_cnt", int'(m_if.evt_cnt), 0);
        check("rst_tmo", int'(m_if.timeout_err), 0);
        rst = 1'b0;
        tick(1);

        // Basic handshake
        set_rdy(1'b1);
        set_req(1'b1);
        exp_q.push_back(1);
        tick(2);
        check("basic_early", int'(m_if.sig_sync), 0);
        tick(1);
        check("basic_sync", int'(m_if.sig_sync), 1);
        check("basic_busy", int'(m_if.busy), 1);
        tick(1);
        check("basic_sync_1cyc", int'(m_if.sig_sync), 0);
        check("basic_ack", int'(m_if.ack_out), 1);
        set_req(1'b0);
        tick(2);
        check("basic_ack_hold", int'(m_if.ack_out), 1);
        tick(1);
        check("basic_ack_fall", int'(m_if.ack_out), 0);
        check("basic_idle", int'(m_if.busy), 0);
        tick(1);

        // Backpressure
        set_rdy(1'b0);
        set_req(1'b1);
        exp_q.push_back(2);
        tick(3);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_if.sig_sync && !m_if.ack_out) held++;
            if (i < 9) tick(1);
        end
        check("bp_held", held, 10);
        set_rdy(1'b1);
        tick(1);
        check("bp_sync_drop", int'(m_if.sig_sync), 0);
        check("bp_ack", int'(m_if.ack_out), 1);
        set_req(1'b0);
        tick(3);
        check("bp_ack_fall", int'(m_if.ack_out), 0);
        tick(1);

        // Held request: one event only
        set_rdy(1'b1);
        set_req(1'b1);
        exp_q.push_back(3);
        tick(50);
        check("held_ack", int'(m_if.ack_out), 1);
        check("held_cnt", int'(m_if.evt_cnt), 3);
        check("held_tmo", int'(m_if.timeout_err), EXP_TMO);
        set_req(1'b0);
        tick(3);
        check("held_ack_fall", int'(m_if.ack_out), 0);
        check("tmo_sticky", int'(m_if.timeout_err), EXP_TMO);

        // Two more handshakes drive the 2-bit counter into saturation
        handshake(4);
        handshake(5);

        // Source drops req while PEND
        set_rdy(1'b0);
        set_req(1'b1);
        exp_q.push_back(6);
        tick(3);
        check("viol_sync", int'(m_if.sig_sync), 1);
        set_req(1'b0);
        tick(2);
        set_rdy(1'b1);
        tick(1);
        check("viol_ack", int'(m_if.ack_out), 1);
        tick(1);
        check("viol_ack_pulse", int'(m_if.ack_out), 0);
        check("viol_idle", int'(m_if.busy), 0);
        tick(1);

        // Reset while PEND
        set_rdy(1'b0);
        set_req(1'b1);
        tick(3);
        check("mid_sync", int'(m_if.sig_sync), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_sync", int'(m_if.sig_sync), 0);
        check("mid_rst_busy", int'(m_if.busy), 0);
        check("mid_rst_cnt", int'(m_if.evt_cnt), 0);
        check("mid_rst_tmo", int'(m_if.timeout_err), 0);
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        set_rdy(1'b1);
        exp_q.push_back(1);
        tick(2);
        check("rel_early", int'(m_if.sig_sync), 0);
        tick(1);
        check("rel_sync", int'(m_if.sig_sync), 1);
        tick(1);
        check("rel_ack", int'(m_if.ack_out), 1);
        set_req(1'b0);
        tick(3);
        check("rel_idle", int'(m_if.busy), 0);
        tick(2);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
